// File: rtl/mem_ex_pkg.sv
// Shared types and helpers for the mem_ex_init storage element.
package mem_ex_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } mem_state_e;

  localparam int DEF_INIT_VAL = 0;

  // Even parity bit over a word of up to 32 bits (callers zero-extend).
  function automatic logic even_par(input logic [31:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/mem_ex_init_if.sv
// Request/response bundle for mem_ex_init; slave is the memory side.
interface mem_ex_init_if #(
  parameter int a_height = 4,
  parameter int d_width  = 4
);
  logic                read;
  logic                wr;
  logic [a_height-1:0] addr;
  logic [d_width-1:0]  din;
  logic                inj;
  logic [d_width-1:0]  out;
  logic                out_valid;
  logic                busy;
  logic                par_err;

  modport slave (
    input  read, wr, addr, din, inj,
    output out, out_valid, busy, par_err
  );

  modport master (
    output read, wr, addr, din, inj,
    input  out, out_valid, busy, par_err
  );
endinterface

// File: rtl/mem_ex_array.sv
// Storage array: synchronous write, registered read (old data on a same-address write).
module mem_ex_array #(
  parameter int a_height = 4,
  parameter int width    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic                re,
  input  logic [a_height-1:0] addr,
  input  logic [width-1:0]    wdata,
  output logic [width-1:0]    rdata
);

  logic [width-1:0] mem_q [2**a_height];
  logic [width-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  // Only the read register is reset; contents are cleared by the init sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_ex_init.sv
// Single-port memory with post-reset clear, registered reads and selectable
// read-during-write policy. Define MEM_EX_PARITY_EN to store and check per-word parity.
module mem_ex_init
  import mem_ex_pkg::*;
#(
  parameter int                 a_height = 4,
  parameter int                 d_width  = 4,
  parameter int                 wr_first = 0,
  parameter logic [d_width-1:0] init_val = d_width'(DEF_INIT_VAL)
) (
  input logic          clk,
  input logic          rst,
  mem_ex_init_if.slave bus
);

`ifdef MEM_EX_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int                  W       = d_width + PW;
  localparam logic [a_height-1:0] CNT_MAX = '1;

  mem_state_e          state_q;
  logic [a_height-1:0] cnt_q;
  logic                busy_q;
  logic                out_valid_q;
  logic                byp_sel_q;
  logic [W-1:0]        byp_q;

  logic [W-1:0]        usr_word;
  logic [W-1:0]        init_word;
  logic [W-1:0]        arr_wdata;
  logic [W-1:0]        arr_rdata;
  logic [W-1:0]        word_sel;
  logic [a_height-1:0] arr_addr;
  logic                arr_we;
  logic                arr_re;

`ifdef MEM_EX_PARITY_EN
  assign usr_word  = {even_par(32'(bus.din)) ^ bus.inj, bus.din};
  assign init_word = {even_par(32'(init_val)), init_val};
`else
  logic unused_inj;
  assign unused_inj = bus.inj;
  assign usr_word   = bus.din;
  assign init_word  = init_val;
`endif

  always_comb begin
    arr_we    = 1'b0;
    arr_addr  = bus.addr;
    arr_wdata = usr_word;
    if (!rst) begin
      if (state_q == ST_INIT) begin
        arr_we    = 1'b1;
        arr_addr  = cnt_q;
        arr_wdata = init_word;
      end else begin
        arr_we = bus.wr;
      end
    end
  end

  assign arr_re = !rst && (state_q == ST_RUN) && bus.read;

  mem_ex_array #(
    .a_height (a_height),
    .width    (W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      busy_q      <= 1'b1;
      out_valid_q <= 1'b0;
      byp_sel_q   <= 1'b0;
      byp_q       <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          out_valid_q <= 1'b0;
          cnt_q       <= cnt_q + 1'b1;
          if (cnt_q == CNT_MAX) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          out_valid_q <= bus.read;
          // The bypass choice is latched with the read so out holds between reads.
          if (bus.read) begin
            byp_sel_q <= (wr_first != 0) && bus.wr;
            byp_q     <= usr_word;
          end
        end
      endcase
    end
  end

  assign word_sel      = byp_sel_q ? byp_q : arr_rdata;
  assign bus.out       = word_sel[d_width-1:0];
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;

`ifdef MEM_EX_PARITY_EN
  assign bus.par_err = out_valid_q &&
                       (even_par(32'(word_sel[d_width-1:0])) != word_sel[W-1]);
`else
  assign bus.par_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_ex_init.sv
// Directed bench for mem_ex_init: two instances, read-first and write-first.
module tb_mem_ex_init;

  localparam logic [3:0] INIT = 4'h5;
`ifdef MEM_EX_PARITY_EN
  localparam logic PAR = 1'b1;
`else
  localparam logic PAR = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mem_ex_init_if #(.a_height(4), .d_width(4)) if0 ();
  mem_ex_init_if #(.a_height(4), .d_width(4)) if1 ();

  mem_ex_init #(.a_height(4), .d_width(4), .wr_first(0), .init_val(INIT)) dut0 (
    .clk (clk), .rst (rst), .bus (if0)
  );
  mem_ex_init #(.a_height(4), .d_width(4), .wr_first(1), .init_val(INIT)) dut1 (
    .clk (clk), .rst (rst), .bus (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, time %0t required < 200000", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      $display("t=%0t %s obs=%0h exp=%0h ok", $time, tag, obs, exp);
    end else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [3:0] a,
                       input logic [3:0] d, input logic j);
    if0.read = r; if0.wr = w; if0.addr = a; if0.din = d; if0.inj = j;
    if1.read = r; if1.wr = w; if1.addr = a; if1.din = d; if1.inj = j;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count out the clear sequence: busy stays high through edge 14, low after edge 15.
  task automatic check_init(input string tag);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk({tag, "_busy0"}, 32'(if0.busy), 32'(i < 15));
      chk({tag, "_busy1"}, 32'(if1.busy), 32'(i < 15));
      chk({tag, "_nvalid"}, 32'(if0.out_valid | if1.out_valid), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b1, 4'd3, 4'hF, 1'b0);
    tick();
    tick();
    chk("rst_out0", 32'(if0.out), 32'd0);
    chk("rst_out1", 32'(if1.out), 32'd0);
    chk("rst_valid", 32'(if0.out_valid | if1.out_valid), 32'd0);
    chk("rst_busy", 32'(if0.busy & if1.busy), 32'd1);
    chk("rst_perr", 32'(if0.par_err | if1.par_err), 32'd0);

    // Requests held during init must be dropped.
    rst = 1'b0;
    check_init("init");

    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 4'(i), 4'h0, 1'b0);
      tick();
      chk("clr_rd0", 32'(if0.out), 32'(INIT));
      chk("clr_rd1", 32'(if1.out), 32'(INIT));
      chk("clr_val", 32'(if0.out_valid & if1.out_valid), 32'd1);
    end

    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 1'b1, 4'(k), 4'(k), 1'b0);
      tick();
      chk("wr_nvalid", 32'(if0.out_valid), 32'd0);
    end
    for (int k = 15; k >= 0; k--) begin
      drive(1'b1, 1'b0, 4'(k), 4'h0, 1'b0);
      tick();
      chk("seq_rd0", 32'(if0.out), 32'(k));
      chk("seq_rd1", 32'(if1.out), 32'(k));
      chk("seq_val", 32'(if0.out_valid & if1.out_valid), 32'd1);
    end
    drive(1'b0, 1'b0, 4'd9, 4'h0, 1'b0);
    tick();
    chk("idle_nvalid", 32'(if0.out_valid | if1.out_valid), 32'd0);
    chk("idle_hold", 32'(if0.out), 32'd0);

    // Read-during-write on address 5: old 0x3, new 0xA.
    drive(1'b0, 1'b1, 4'd5, 4'h3, 1'b0);
    tick();
    drive(1'b1, 1'b1, 4'd5, 4'hA, 1'b0);
    tick();
    chk("rdw_rfirst", 32'(if0.out), 32'h3);
    chk("rdw_wfirst", 32'(if1.out), 32'hA);
    drive(1'b1, 1'b0, 4'd5, 4'h0, 1'b0);
    tick();
    chk("rdw_after0", 32'(if0.out), 32'hA);
    chk("rdw_after1", 32'(if1.out), 32'hA);
    drive(1'b0, 1'b0, 4'd0, 4'h0, 1'b0);
    tick();
    chk("rdw_hold1", 32'(if1.out), 32'hA);

    // Reset mid-operation, then again at init cycle 7.
    rst = 1'b1;
    tick();
    chk("mid_rst_out", 32'(if0.out | if1.out), 32'd0);
    chk("mid_rst_busy", 32'(if0.busy), 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("c7_busy", 32'(if0.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_init("reinit");
    drive(1'b1, 1'b0, 4'd12, 4'h0, 1'b0);
    tick();
    chk("reclr_12", 32'(if0.out), 32'(INIT));
    drive(1'b1, 1'b0, 4'd5, 4'h0, 1'b0);
    tick();
    chk("reclr_5", 32'(if1.out), 32'(INIT));

    // Parity injection on address 2.
    drive(1'b0, 1'b1, 4'd2, 4'h6, 1'b1);
    tick();
    drive(1'b1, 1'b0, 4'd2, 4'h0, 1'b0);
    tick();
    chk("inj_out", 32'(if0.out), 32'h6);
    chk("inj_perr0", 32'(if0.par_err), 32'(PAR));
    chk("inj_perr1", 32'(if1.par_err), 32'(PAR));
    drive(1'b0, 1'b1, 4'd2, 4'h6, 1'b0);
    tick();
    drive(1'b1, 1'b0, 4'd2, 4'h0, 1'b0);
    tick();
    chk("clean_out", 32'(if0.out), 32'h6);
    chk("clean_perr", 32'(if0.par_err | if1.par_err), 32'd0);
    // Bypass path carries the injected parity; read-first sees the clean stored word.
    drive(1'b1, 1'b1, 4'd2, 4'h6, 1'b1);
    tick();
    chk("byp_perr0", 32'(if0.par_err), 32'd0);
    chk("byp_perr1", 32'(if1.par_err), 32'(PAR));
    drive(1'b0, 1'b0, 4'd0, 4'h0, 1'b0);
    tick();
    chk("perr_idle", 32'(if0.par_err | if1.par_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_ex_init.md
# mem_ex_init

Parametrised single-port synchronous memory and successor to the basic `Mem_ex` array. Adds:

- a self-clearing initialisation sequencer after reset;
- registered reads with a valid strobe;
- a selectable read-during-write policy;
- optional per-word parity checking.

It is the standard storage element for small register files and lookup buffers in the design.

## Interface
Parameters:
- `a_height`, 4, address width; depth = 2**a_height
- `d_width`, 4, data word width
- `wr_first`, 0, read-during-write policy: 0 = read-first (old data), 1 = write-first (new data)
- `init_val`, 0, d_width-bit value written to every word during initialisation

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `read`  in  1  read request, sampled at rising edge
- `wr`  in  1  write request, sampled at rising edge
- `addr`  in  a_height  word address for read and/or write
- `din`  in  d_width  write data
- `inj`  in  1  parity-error injection on write (see Configuration)
- `out`  out  d_width  registered read data
- `out_valid`  out  1  one-cycle strobe, `out` updated this cycle
- `busy`  out  1  initialisation in progress, requests ignored
- `par_err`  out  1  parity mismatch on current `out_valid` word

## Operation
- FSM states: `ST_INIT`, `ST_RUN`.
- Reset behaviour:
  - `rst`=1 forces `ST_INIT` and clear counter = 0.
  - Outputs while in reset: `out`=0, `out_valid`=0, `par_err`=0, `busy`=1.
- `ST_INIT`:
  - Each cycle with `rst`=0, writes `init_val` (with correct parity) to the counter address, then increments the counter.
  - After writing address 2**a_height-1, moves to `ST_RUN`.
- `ST_RUN`:
  - `wr`=1 writes `din` to `addr`.
  - `read`=1 captures the word at `addr` into `out` and asserts `out_valid` the next cycle.
- Idle and ignored requests:
  - `out` holds its last value when no read occurs.
  - `read`/`wr` asserted during `ST_INIT` are dropped with no side effects: no `out_valid`, no array write.
- `read` and `wr` together to the same address:
  - `wr_first`=0: `out` = previous contents.
  - `wr_first`=1: `out` = `din`.
  - The write always completes.
- `rst` asserted mid-initialisation or mid-operation restarts the clear from address 0; the array is fully re-cleared.
- Address wrap is not applicable: `addr` always spans exactly the full depth.

## Timing
- Initialisation:
  - Let cycle 0 be the first rising edge with `rst`=0. Edges 0 .. 2**a_height-1 write addresses 0 .. 2**a_height-1.
  - `busy` falls after edge 2**a_height-1, i.e. `busy`=1 for exactly 2**a_height cycles after reset release.
  - First accepted request is on edge 2**a_height.
- Read latency is 1 cycle: request sampled at edge N gives `out`/`out_valid` valid after edge N; `out_valid` is deasserted after edge N+1 unless another read occurs.
- Back-to-back reads every cycle produce `out_valid` held high and a new word each cycle.
- Write latency is 1 cycle: a read of the same address on the following edge returns the new data under either policy.

## Configuration
- Macro `MEM_EX_PARITY_EN`.
- Defined:
  - Array stores d_width+1 bits: data plus even parity of data.
  - On write, the stored parity bit is inverted when `inj`=1.
  - On read, parity is recomputed. `par_err`=1 coincident with `out_valid` when it mismatches, 0 otherwise.
  - Write-first bypass reports parity of `din` XOR `inj`.
- Undefined:
  - Array is d_width bits.
  - `inj` is ignored.
  - `par_err` is tied 0.
  - All other behaviour is identical.

## Structure
- Shared package `mem_ex_pkg`:
  - FSM state enum (`ST_INIT`, `ST_RUN`)
  - function `even_par(data)`
  - localparam for default `init_val`
- One sub-module, `mem_ex_array`:
  - Storage only: synchronous write, registered read of width d_width(+1).
  - Bypass mux and FSM stay in the top level.

## Test plan
- Reset then release, with `read`/`wr` held 1 on address 3 during init:
  - `busy`=1 exactly 16 cycles (a_height=4).
  - No `out_valid`.
  - Afterwards, reading all 16 addresses returns `init_val`.
- Write address k with data k for k=0..15, then read 15..0 one per cycle:
  - `out` = 15,14,..,0 on consecutive cycles.
  - `out_valid` continuously 1.
- Read+write address 5 together (old 0x3, `din` 0xA):
  - `wr_first`=0 gives `out`=0x3.
  - `wr_first`=1 gives `out`=0xA.
  - Next read of address 5 gives 0xA.
- Assert `rst` at init cycle 7, release:
  - `busy` restarts for a full 16 cycles.
  - Previously written address 12 (0xC) reads `init_val`.
- With `MEM_EX_PARITY_EN`, write address 2 = 0x6 with `inj`=1, then read:
  - `out`=0x6, `par_err`=1.
  - Rewrite with `inj`=0 and read: `par_err`=0.
  - Without the macro, `par_err` is always 0.
